// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the seven-segment scan controller.
//   seg_state_e : scan FSM states (IDLE, BLANK, SHOW)
//   SEG_*       : segment patterns, bits [6:0] = g..a, active high
//   DP_BIT      : bit position of the decimal point in the 8-bit pattern
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } seg_state_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int unsigned DP_BIT = 7;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit code to seven-segment pattern decoder.
//   i_code    : digit code (0-9 digits, 10-14 dash, 15 blank)
//   i_dp      : decimal-point enable
//   o_pattern : 8-bit pattern, [6:0] = g..a, [7] = dp, active high
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_dp,
    output logic [7:0] o_pattern
);

    logic [6:0] w_seg;

    always_comb begin
        w_seg = SEG_BLANK;
        case (i_code)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14: w_seg = SEG_DASH;
            default: w_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        o_pattern         = 8'h00;
        o_pattern[6:0]    = w_seg;
        o_pattern[DP_BIT] = i_dp;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-select
// seven-segment display. Writes land in shadow registers and are copied to
// the active (displayed) registers only at frame boundaries or while idle.
//   clk, rst_n         : clock, synchronous active-low reset
//   en                 : scan enable; low blanks the display and parks at digit 0
//   wr_valid/wr_ready  : write handshake (ready never stalls after reset)
//   wr_addr/data/dp    : digit index, 4-bit code, decimal-point bit
//   wr_err             : one-cycle pulse for an accepted out-of-range write
//   SEG_SEL            : one-hot digit select, active high
//   SEG_DATA           : segment pattern, [6:0] = g..a, [7] = dp
//   frame_done         : one-cycle pulse after the last digit slot ends
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 5,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    output logic                  wr_err,
    output logic [NUM_DIGITS-1:0] SEG_SEL,
    output logic [7:0]            SEG_DATA,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    seg_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIG_W-1:0]      r_dig;
    logic [3:0]            r_shadow    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_shadow_dp;
    logic [3:0]            r_active    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic                  r_ready;
    logic                  r_err;
    logic [NUM_DIGITS-1:0] r_sel;
    logic [7:0]            r_data;
    logic                  r_frame_done;

    logic                  w_wr_acc;
    logic                  w_addr_ok;
    logic [3:0]            w_shadow_nxt [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_dp_nxt;
    logic [3:0]            w_cur_code;
    logic                  w_cur_dp;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [7:0]            w_pattern;

    assign w_wr_acc  = wr_valid && r_ready;
    assign w_addr_ok = 32'(wr_addr) < NUM_DIGITS;

    // Shadow next-state including this cycle's write; also feeds the commit so
    // a write accepted on the commit edge is not lost for a whole frame.
    always_comb begin
        w_dp_nxt = r_shadow_dp;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            w_shadow_nxt[d] = r_shadow[d];
            if (w_wr_acc && (wr_addr == ADDR_W'(d))) begin
                w_shadow_nxt[d] = wr_data;
                w_dp_nxt[d]     = wr_dp;
            end
        end
    end

    // Current digit select and its active code. The digit index never changes
    // on an edge that enters or stays in SHOW, so r_dig is the right index.
    always_comb begin
        w_cur_code = 4'hF;
        w_cur_dp   = 1'b0;
        w_onehot   = '0;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (r_dig == DIG_W'(d)) begin
                w_cur_code  = r_active[d];
                w_cur_dp    = r_active_dp[d];
                w_onehot[d] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .i_code    (w_cur_code),
        .i_dp      (w_cur_dp),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_dig        <= '0;
            for (int d = 0; d < int'(NUM_DIGITS); d++) begin
                r_shadow[d] <= 4'hF;
                r_active[d] <= 4'hF;
            end
            r_shadow_dp  <= '0;
            r_active_dp  <= '0;
            r_ready      <= 1'b0;
            r_err        <= 1'b0;
            r_sel        <= '0;
            r_data       <= 8'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_ready      <= 1'b1;
            r_err        <= w_wr_acc && !w_addr_ok;
            r_shadow     <= w_shadow_nxt;
            r_shadow_dp  <= w_dp_nxt;
            r_frame_done <= 1'b0;

            if (!en) begin
                // Idle commits every edge so the display is current on re-enable.
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_dig       <= '0;
                r_sel       <= '0;
                r_data      <= 8'h00;
                r_active    <= w_shadow_nxt;
                r_active_dp <= w_dp_nxt;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        r_dig   <= '0;
                        r_sel   <= '0;
                        r_data  <= 8'h00;
                    end
                    BLANK: begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= SHOW;
                            r_sel   <= w_onehot;
                            r_data  <= w_pattern;
                        end else begin
                            r_sel  <= '0;
                            r_data <= 8'h00;
                        end
                    end
                    SHOW: begin
                        if (r_cnt == SLOT_LAST) begin
                            r_state <= BLANK;
                            r_cnt   <= '0;
                            r_sel   <= '0;
                            r_data  <= 8'h00;
                            if (r_dig == DIG_LAST) begin
                                r_dig        <= '0;
                                r_frame_done <= 1'b1;
                                r_active     <= w_shadow_nxt;
                                r_active_dp  <= w_dp_nxt;
                            end else begin
                                r_dig <= r_dig + DIG_W'(1);
                            end
                        end else begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_sel  <= w_onehot;
                            r_data <= w_pattern;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_dig   <= '0;
                        r_sel   <= '0;
                        r_data  <= 8'h00;
                    end
                endcase
            end
        end
    end

    assign wr_ready   = r_ready;
    assign wr_err     = r_err;
    assign SEG_SEL    = r_sel;
    assign SEG_DATA   = r_data;
    assign frame_done = r_frame_done;

endmodule
